// File: rtl/uart_fifo_receiver.sv
// uart_fifo_receiver: UART receiver with synchroniser, glitch rejection, break handling and a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to build the parity state and checker.
module uart_fifo_receiver #(
  parameter int CLK_CYCLES     = 4167,
  parameter int CTR_WIDTH      = 16,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int FIFO_LOG_DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_rx,
  output logic [DATA_BITS-1:0]      dout,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      valid,
  input  logic                      ready,
  output logic [FIFO_LOG_DEPTH:0]   count,
  output logic                      overrun,
  input  logic                      clear_ovr,
  output logic                      busy
);
  localparam int DEPTH = 2 ** FIFO_LOG_DEPTH;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CTR_WIDTH-1:0] HALF = CTR_WIDTH'(CLK_CYCLES / 2 - 1);
  localparam logic [CTR_WIDTH-1:0] FULL = CTR_WIDTH'(CLK_CYCLES - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  localparam state_t AFTER_DATA = state_t'((PARITY != 0) ? S_PARITY : S_STOP);
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  localparam state_t AFTER_DATA = S_STOP;
`endif
  state_t                    state_q, state_d;
  logic [1:0]                sync_q;
  logic                      rx_s;
  logic [CTR_WIDTH-1:0]      ctr_q, ctr_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]      sh_q, sh_d;
  logic                      perr_q, perr_d;
  logic [DATA_BITS+1:0]      mem_q [DEPTH];
  logic [FIFO_LOG_DEPTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_LOG_DEPTH:0]   cnt_q, cnt_d;
  logic                      ovr_q, ovr_d;
  logic                      sample, push, pop, full, wr_en;

  assign rx_s   = sync_q[1];
  assign sample = ctr_q == '0;

  always_comb begin
    state_d = state_q;
    ctr_d   = state_q == S_IDLE ? HALF : sample ? FULL : ctr_q - 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE:  state_d = rx_s ? S_IDLE : S_START;
      S_START: if (sample) begin
        state_d = rx_s ? S_IDLE : S_DATA;
        idx_d   = '0;
        perr_d  = 1'b0;
      end
      S_DATA: if (sample) begin
        sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(DATA_BITS - 1)) state_d = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (sample) begin
        perr_d  = (^sh_q ^ rx_s) != (PARITY == 1);
        state_d = S_STOP;
      end
`endif
      S_STOP: if (sample) begin
        push    = 1'b1;
        state_d = rx_s ? S_IDLE : S_BREAK;
      end
      S_BREAK: state_d = rx_s ? S_IDLE : S_BREAK;
      default: state_d = S_IDLE;
    endcase
  end

  assign valid = cnt_q != '0;
  assign pop   = valid && ready;
  assign full  = cnt_q == (FIFO_LOG_DEPTH+1)'(DEPTH);

  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    wr_en = push && (!full || pop);
    wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + {{FIFO_LOG_DEPTH{1'b0}}, wr_en} - {{FIFO_LOG_DEPTH{1'b0}}, pop};
    ovr_d = (push && !wr_en) || (ovr_q && !clear_ovr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      ctr_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {perr_q, ~rx_s, sh_q};
  end

  assign {parity_err, frame_err, dout} = valid ? mem_q[rd_q] : '0;
  assign count   = cnt_q;
  assign overrun = ovr_q;
  assign busy    = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_fifo_receiver.sv
// tb_uart_fifo_receiver: directed frames checked every cycle against a queue-level FIFO model.
module tb_uart_fifo_receiver;
  localparam int PAR = 2;
  logic       clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, ready = 1'b0, clear_ovr = 1'b0;
  logic [7:0] dout;
  logic       frame_err, parity_err, valid, overrun, busy;
  logic [2:0] count;

  uart_fifo_receiver #(.CLK_CYCLES(16), .CTR_WIDTH(16), .DATA_BITS(8), .PARITY(PAR), .FIFO_LOG_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .dout(dout), .frame_err(frame_err),
    .parity_err(parity_err), .valid(valid), .ready(ready), .count(count), .overrun(overrun),
    .clear_ovr(clear_ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int at; logic [9:0] w;} ev_t;
  ev_t        sched[$];
  logic [9:0] q[$];
  logic       m_ovr = 1'b0;
  int         cyc = 0, bf = 0, bt = -1, lit_cyc = -10;
  logic [9:0] lit_w = '0;
  int         n_cmp = 0, n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endfunction

  // model: words land 155 (+16 with parity) edges after the line falls
  always @(posedge clk) begin : model
    bit popped, pushed, was_full;
    logic [9:0] w;
    cyc++;
    if (reset) begin
      q.delete();
      sched.delete();
      m_ovr = 1'b0;
    end else begin
      popped   = q.size() != 0 && ready;
      pushed   = sched.size() != 0 && sched[0].at == cyc;
      was_full = q.size() == 4;
      w = '0;
      if (pushed) begin
        w = sched[0].w;
        void'(sched.pop_front());
      end
      if (popped) void'(q.pop_front());
      if (pushed && (!was_full || popped)) q.push_back(w);
      if (pushed && was_full && !popped) m_ovr = 1'b1;
      else if (clear_ovr) m_ovr = 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (reset) begin
      chk("rst_valid", valid, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("valid", valid, q.size() != 0);
      chk("count", count, q.size());
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, cyc >= bf && cyc <= bt);
      if (q.size() != 0) chk("head", {parity_err, frame_err, dout}, q[0]);
      if (cyc == lit_cyc) begin
        chk("lit_valid", valid, 1);
        chk("lit_word", {parity_err, frame_err, dout}, lit_w);
      end
      if (cyc == lit_cyc + 1) chk("lit_popped", valid, 0);
    end
  end

  // called on a falling edge; pbit<0 means no parity bit; nper>0 truncates the frame
  task automatic send(input logic [7:0] d, input logic stop, input int pbit, input int nper);
    logic [10:0] bits;
    int p, nb;
    logic pe;
    ev_t e;
    p    = pbit < 0 ? 0 : 1;
    nb   = 10 + p;
    bits = {3'b111, d, 1'b0};
    if (p != 0) bits[9] = pbit[0];
    bits[nb-1] = stop;
    pe = p != 0 && ((($countones(d) + pbit) % 2) != (PAR == 1 ? 1 : 0));
    bf = cyc + 3;
    bt = (nper == 0 && stop) ? cyc + 154 + 16 * p : 32'h3fff_ffff;
    if (nper == 0) begin
      e.at = cyc + 155 + 16 * p;
      e.w  = {pe, ~stop, d};
      sched.push_back(e);
    end
    for (int i = 0; i < (nper == 0 ? nb : nper); i++) begin
      uart_rx = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_dout", dout, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_flags", {frame_err, parity_err}, 0);
    repeat (4) @(negedge clk);
    ready = 1'b1;
    lit_cyc = cyc + 155;
    lit_w   = {2'b00, 8'hA5};
    send(8'hA5, 1'b1, -1, 0);
    repeat (10) @(negedge clk);
    bf = cyc + 3;
    bt = cyc + 10;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_count", count, 0);
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1, 0);
    repeat (5) @(negedge clk);
    chk("ovr_count", count, 4);
    chk("ovr_flag", overrun, 1);
    chk("ovr_head", dout, 8'h01);
    ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain_count", count, 0);
    chk("ovr_sticky", overrun, 1);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    ready = 1'b0;
    send(8'h3C, 1'b0, -1, 0);
    repeat (84) @(negedge clk);
    uart_rx = 1'b1;
    bt = cyc + 2;
    repeat (20) @(negedge clk);
    chk("brk_count", count, 1);
    chk("brk_word", {frame_err, dout}, {1'b1, 8'h3C});
    send(8'h55, 1'b1, -1, 0);
    repeat (5) @(negedge clk);
    chk("brk_next_count", count, 2);
    ready = 1'b1;
    repeat (5) @(negedge clk);
`ifdef UART_RX_PARITY_EN
    lit_cyc = cyc + 171;
    lit_w   = {2'b00, 8'h07};
    send(8'h07, 1'b1, 1, 0);
    lit_cyc = cyc + 171;
    lit_w   = {2'b10, 8'h07};
    send(8'h07, 1'b1, 0, 0);
    repeat (5) @(negedge clk);
`endif
    ready = 1'b0;
    send(8'h33, 1'b1, -1, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_count", count, 1);
    send(8'hFF, 1'b1, -1, 5);
    reset = 1'b1;
    bt = -1;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dout", dout, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h12, 1'b1, -1, 0);
    repeat (5) @(negedge clk);
    chk("post_rst_count", count, 1);
    chk("post_rst_word", {frame_err, dout}, {1'b0, 8'h12});
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
